// File: rtl/trace_fmt_pkg.sv
// Shared definitions for the trace-line serializer: FSM states, ASCII
// constants, checker format codes, clamp limit and character helpers.
package trace_fmt_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CONV,
      ST_CARET,
      ST_TIME,
      ST_AT,
      ST_PC,
      ST_COLON,
      ST_SP1,
      ST_MARK,
      ST_OPND,
      ST_SP2,
      ST_LT,
      ST_EQ,
      ST_SP3,
      ST_DATA,
      ST_HASH
   } state_t;

   localparam logic [7:0] CH_CARET  = 8'h5e;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3a;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2a;
   localparam logic [7:0] CH_LT     = 8'h3c;
   localparam logic [7:0] CH_EQ     = 8'h3d;
   localparam logic [7:0] CH_HASH   = 8'h23;

   localparam logic [1:0] FMT_REG = 2'b01;
   localparam logic [1:0] FMT_STO = 2'b10;

   localparam logic [13:0] CLAMP_MAX = 14'd9999;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else
         return 8'h57 + {4'h0, n};
   endfunction

   function automatic logic [7:0] dec_char(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   // Significant decimal digits of a 4-digit BCD value; 0 still has one.
   function automatic logic [2:0] dec_len(input logic [15:0] b);
      if (b[15:12] != 4'h0)
         return 3'd4;
      else if (b[11:8] != 4'h0)
         return 3'd3;
      else if (b[7:4] != 4'h0)
         return 3'd2;
      else
         return 3'd1;
   endfunction

endpackage

// File: rtl/trace_bcd_conv.sv
// Iterative double-dabble: 14-bit binary to 4 BCD digits in 14 shifts.
// Ports: clk, reset, start (loads bin), done, digits[15:0].
// start loads on its edge; the 14 following edges shift. done is high
// in the cycle whose closing edge performs the final shift, so digits
// are valid from that edge until the next start.
module trace_bcd_conv
   import trace_fmt_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        done,
   output logic [15:0] digits
);

   logic [13:0] sh;
   logic [3:0]  cnt;
   logic        busy;
   logic [15:0] adj;

   always_comb begin
      adj = digits;
      for (int i = 0; i < 4; i++) begin
         if (digits[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sh     <= '0;
         digits <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= busy && (cnt == 4'd12);
         if (start) begin
            sh     <= bin;
            digits <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
         end else if (busy) begin
            {digits, sh} <= {adj[14:0], sh, 1'b0};
            cnt          <= cnt + 4'd1;
            if (cnt == 4'd13)
               busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/trace_line_serializer.sv
// Serializes one binary trace record into an ASCII trace line, 1 char/clk.
// Ports: clk, reset, rec_* record handshake/fields, char/char_valid
// stream, line_done on "#", ovf sticky clamp flag.
module trace_line_serializer
   import trace_fmt_pkg::*;
#(
   parameter int unsigned SP_COLON  = 1,
   parameter int unsigned SP_LT     = 1,
   parameter int unsigned SP_EQ     = 1,
   parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rec_valid,
   output logic        rec_ready,
   input  logic [13:0] rec_time,
   input  logic [31:0] rec_pc,
   input  logic        rec_is_mem,
   input  logic [13:0] rec_reg,
   input  logic [31:0] rec_addr,
   input  logic [31:0] rec_data,
   output logic [7:0]  char,
   output logic        char_valid,
   output logic        line_done,
   output logic        ovf
);

   localparam logic [2:0] SPC_I = 3'(SP_COLON - 1);
   localparam logic [2:0] SPL_I = 3'(SP_LT - 1);
   localparam logic [2:0] SPE_I = 3'(SP_EQ - 1);

   state_t      state;
   logic [2:0]  idx;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic [31:0] data_q;
   logic [1:0]  fmt_q;

   logic        time_ovf;
   logic        reg_ovf;
   logic [13:0] time_c;
   logic [13:0] reg_c;
   logic        accept;
   logic        is_mem;

   logic [15:0] t_bcd;
   logic [15:0] r_bcd;
   logic        t_done;
   logic        r_done;

   logic [3:0]  nib_pc;
   logic [3:0]  nib_addr;
   logic [3:0]  nib_data;
   logic [3:0]  dig_t;
   logic [3:0]  dig_r;

   assign time_ovf  = rec_time > CLAMP_MAX;
   assign reg_ovf   = rec_reg > CLAMP_MAX;
   assign time_c    = time_ovf ? CLAMP_MAX : rec_time;
   assign reg_c     = reg_ovf ? CLAMP_MAX : rec_reg;
   assign rec_ready = (state == ST_IDLE);
   assign accept    = rec_valid && rec_ready;
   assign is_mem    = (fmt_q == FMT_STO);

   // idx walks each field from its most significant position down to 0.
   assign nib_pc   = pc_q[{idx, 2'b00} +: 4];
   assign nib_addr = addr_q[{idx, 2'b00} +: 4];
   assign nib_data = data_q[{idx, 2'b00} +: 4];
   assign dig_t    = t_bcd[{idx[1:0], 2'b00} +: 4];
   assign dig_r    = r_bcd[{idx[1:0], 2'b00} +: 4];

   trace_bcd_conv u_time_conv (
      .clk    (clk),
      .reset  (reset),
      .start  (accept),
      .bin    (time_c),
      .done   (t_done),
      .digits (t_bcd)
   );

   trace_bcd_conv u_reg_conv (
      .clk    (clk),
      .reset  (reset),
      .start  (accept),
      .bin    (reg_c),
      .done   (r_done),
      .digits (r_bcd)
   );

   // The char register shows the character of the state it leaves, so
   // each state's character appears one cycle after entering it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         pc_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         fmt_q      <= FMT_REG;
         char       <= IDLE_CHAR;
         char_valid <= 1'b0;
         line_done  <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         char       <= IDLE_CHAR;
         char_valid <= 1'b1;
         line_done  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               char_valid <= 1'b0;
               if (accept) begin
                  pc_q   <= rec_pc;
                  addr_q <= rec_addr;
                  data_q <= rec_data;
                  fmt_q  <= rec_is_mem ? FMT_STO : FMT_REG;
                  if (time_ovf || reg_ovf)
                     ovf <= 1'b1;
                  state  <= ST_CONV;
               end
            end
            ST_CONV: begin
               char_valid <= 1'b0;
               if (t_done && r_done)
                  state <= ST_CARET;
            end
            ST_CARET: begin
               char  <= CH_CARET;
               idx   <= dec_len(t_bcd) - 3'd1;
               state <= ST_TIME;
            end
            ST_TIME: begin
               char <= dec_char(dig_t);
               if (idx == 3'd0)
                  state <= ST_AT;
               else
                  idx <= idx - 3'd1;
            end
            ST_AT: begin
               char  <= CH_AT;
               idx   <= 3'd7;
               state <= ST_PC;
            end
            ST_PC: begin
               char <= hex_char(nib_pc);
               if (idx == 3'd0)
                  state <= ST_COLON;
               else
                  idx <= idx - 3'd1;
            end
            ST_COLON: begin
               char <= CH_COLON;
               if (SP_COLON != 0) begin
                  idx   <= SPC_I;
                  state <= ST_SP1;
               end else begin
                  state <= ST_MARK;
               end
            end
            ST_SP1: begin
               char <= CH_SPACE;
               if (idx == 3'd0)
                  state <= ST_MARK;
               else
                  idx <= idx - 3'd1;
            end
            ST_MARK: begin
               char  <= is_mem ? CH_STAR : CH_DOLLAR;
               idx   <= is_mem ? 3'd7 : dec_len(r_bcd) - 3'd1;
               state <= ST_OPND;
            end
            ST_OPND: begin
               char <= is_mem ? hex_char(nib_addr) : dec_char(dig_r);
               if (idx != 3'd0) begin
                  idx <= idx - 3'd1;
               end else if (SP_LT != 0) begin
                  idx   <= SPL_I;
                  state <= ST_SP2;
               end else begin
                  state <= ST_LT;
               end
            end
            ST_SP2: begin
               char <= CH_SPACE;
               if (idx == 3'd0)
                  state <= ST_LT;
               else
                  idx <= idx - 3'd1;
            end
            ST_LT: begin
               char  <= CH_LT;
               state <= ST_EQ;
            end
            ST_EQ: begin
               char <= CH_EQ;
               if (SP_EQ != 0) begin
                  idx   <= SPE_I;
                  state <= ST_SP3;
               end else begin
                  idx   <= 3'd7;
                  state <= ST_DATA;
               end
            end
            ST_SP3: begin
               char <= CH_SPACE;
               if (idx == 3'd0) begin
                  idx   <= 3'd7;
                  state <= ST_DATA;
               end else begin
                  idx <= idx - 3'd1;
               end
            end
            ST_DATA: begin
               char <= hex_char(nib_data);
               if (idx == 3'd0)
                  state <= ST_HASH;
               else
                  idx <= idx - 3'd1;
            end
            ST_HASH: begin
               char      <= CH_HASH;
               line_done <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_line_serializer.sv
// Scoreboard bench for trace_line_serializer: default-spaced instance
// plus a zero-space instance, expected lines queued per record.
module tb_trace_line_serializer;

   logic        clk = 1'b0;
   logic [1:0]  rst;
   logic [1:0]  rv;
   logic [1:0]  mem;
   logic [13:0] rt  [2];
   logic [13:0] rr  [2];
   logic [31:0] rpc [2];
   logic [31:0] ra  [2];
   logic [31:0] rd  [2];
   logic        rdy [2];
   logic [7:0]  ch  [2];
   logic        cv  [2];
   logic        ld  [2];
   logic        ov  [2];

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] expq [2][$];
   int         accq [2][$];
   int         gapq [2][$];
   int         idle_run [2];

   logic [7:0] mon_e;
   int         mon_a;
   int         mon_g;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   trace_line_serializer dut (
      .clk        (clk),
      .reset      (rst[0]),
      .rec_valid  (rv[0]),
      .rec_ready  (rdy[0]),
      .rec_time   (rt[0]),
      .rec_pc     (rpc[0]),
      .rec_is_mem (mem[0]),
      .rec_reg    (rr[0]),
      .rec_addr   (ra[0]),
      .rec_data   (rd[0]),
      .char       (ch[0]),
      .char_valid (cv[0]),
      .line_done  (ld[0]),
      .ovf        (ov[0])
   );

   trace_line_serializer #(
      .SP_COLON (0),
      .SP_LT    (0),
      .SP_EQ    (0)
   ) dut0 (
      .clk        (clk),
      .reset      (rst[1]),
      .rec_valid  (rv[1]),
      .rec_ready  (rdy[1]),
      .rec_time   (rt[1]),
      .rec_pc     (rpc[1]),
      .rec_is_mem (mem[1]),
      .rec_reg    (rr[1]),
      .rec_addr   (ra[1]),
      .rec_data   (rd[1]),
      .char       (ch[1]),
      .char_valid (cv[1]),
      .line_done  (ld[1]),
      .ovf        (ov[1])
   );

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic send(input int k, input int t, input logic [31:0] pc,
                       input bit m, input int r, input logic [31:0] a,
                       input logic [31:0] d, input string s,
                       input int gap, input bit hold, output int acc);
      int n;
      @(negedge clk);
      for (int i = 0; i < s.len(); i++)
         expq[k].push_back(s[i]);
      gapq[k].push_back(gap);
      rt[k]  = 14'(t);
      rr[k]  = 14'(r);
      rpc[k] = pc;
      mem[k] = m;
      ra[k]  = a;
      rd[k]  = d;
      rv[k]  = 1'b1;
      n   = 0;
      acc = -1;
      while (!rdy[k] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout%0d: got ready=0 want ready=1", k);
         rv[k] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc = cyc;
         accq[k].push_back(cyc);
         if (!hold)
            rv[k] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (cv[k]) begin
            if (expq[k].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_char%0d: got %02h want none", k, ch[k]);
            end else begin
               mon_e = expq[k].pop_front();
               chk($sformatf("char%0d", k), 32'(ch[k]), 32'(mon_e));
               chk($sformatf("line_done%0d", k), 32'(ld[k]),
                   32'(mon_e == 8'h23));
               if (mon_e == 8'h5e) begin
                  if (accq[k].size() > 0) begin
                     mon_a = accq[k].pop_front();
                     chk($sformatf("first_char_lat%0d", k),
                         32'(cyc - mon_a), 32'd15);
                  end
                  if (gapq[k].size() > 0) begin
                     mon_g = gapq[k].pop_front();
                     if (mon_g >= 0)
                        chk($sformatf("idle_gap%0d", k),
                            32'(idle_run[k]), 32'(mon_g));
                  end
               end
            end
            idle_run[k] = 0;
         end else begin
            chk($sformatf("idle_out%0d", k), {23'h0, ch[k], ld[k]}, 32'h0);
            idle_run[k]++;
         end
      end
   end

   initial begin
      int acc;
      int a1;
      int a2;
      int n;
      rst = 2'b11;
      rv  = 2'b00;
      mem = 2'b00;
      for (int k = 0; k < 2; k++) begin
         rt[k] = '0; rr[k] = '0; rpc[k] = '0; ra[k] = '0; rd[k] = '0;
         idle_run[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 2'b00;
      @(negedge clk);
      chk("rst_ready", 32'(rdy[0]), 32'd1);
      chk("rst_char", 32'(ch[0]), 32'h00);
      chk("rst_valid", 32'(cv[0]), 32'd0);
      chk("rst_done", 32'(ld[0]), 32'd0);
      chk("rst_ovf", 32'(ov[0]), 32'd0);
      chk("rst_ready1", 32'(rdy[1]), 32'd1);

      send(0, 25, 32'h00003000, 1'b0, 3, 32'h0, 32'h0000abcd,
           "^25@00003000: $3 <= 0000abcd#", -1, 1'b0, acc);
      chk("ovf_clear", 32'(ov[0]), 32'd0);

      send(0, 12345, 32'h00000004, 1'b0, 31, 32'h0, 32'h12345678,
           "^9999@00000004: $31 <= 12345678#", -1, 1'b0, acc);
      chk("ovf_set", 32'(ov[0]), 32'd1);

      send(0, 1000, 32'hcafe0000, 1'b0, 0, 32'h0, 32'h0,
           "^1000@cafe0000: $0 <= 00000000#", -1, 1'b0, acc);
      chk("ovf_sticky", 32'(ov[0]), 32'd1);

      send(0, 7, 32'h00000100, 1'b1, 0, 32'h0000beef, 32'h00c0ffee,
           "^7@00000100: *0000beef <= 00c0ffee#", -1, 1'b1, a1);
      send(0, 9999, 32'hffffffff, 1'b0, 9999, 32'h0, 32'h0,
           "^9999@ffffffff: $9999 <= 00000000#", 15, 1'b0, a2);
      chk("b2b_accept_gap", 32'(a2 - a1), 32'd50);
      chk("ovf_sticky2", 32'(ov[0]), 32'd1);

      send(0, 42, 32'h12345678, 1'b0, 7, 32'h0, 32'h00000001,
           "^42@12345678: $7 <= 00000001#", -1, 1'b0, acc);
      while (cyc < acc + 20) @(negedge clk);
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      expq[0].delete();
      accq[0].delete();
      gapq[0].delete();
      chk("midrst_valid", 32'(cv[0]), 32'd0);
      chk("midrst_char", 32'(ch[0]), 32'h00);
      chk("midrst_ready", 32'(rdy[0]), 32'd1);
      chk("midrst_ovf", 32'(ov[0]), 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;

      send(0, 5, 32'h0000000a, 1'b0, 12, 32'h0, 32'h000000ff,
           "^5@0000000a: $12 <= 000000ff#", -1, 1'b0, acc);

      send(1, 0, 32'hdeadbeef, 1'b1, 0, 32'h00000010, 32'hffffffff,
           "^0@deadbeef:*00000010<=ffffffff#", -1, 1'b0, acc);

      n = 0;
      while ((expq[0].size() != 0 || expq[1].size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(expq[0].size() + expq[1].size()), 32'd0);
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trace_line_serializer.md
Name: trace_line_serializer

Overview:
- Upstream stage of the trace-line format checker.
- Accepts one binary trace record per handshake and emits the record as an ASCII line, one character per clock, on the char stream the checker consumes.
- Line formats:
  - Register write: `^TIME@PC: $REG <= DATA#`
  - Memory write: `^TIME@PC: *ADDR <= DATA#`
- Used to drive the checker with well-formed lines; it is also the golden-line source for checker regression.

Parameters:
- SP_COLON, 1, number of spaces after ":" (range 0..7).
- SP_LT, 1, number of spaces before "<=" (range 0..7).
- SP_EQ, 1, number of spaces after "<=" (range 0..7).
- IDLE_CHAR, 8'h00, value driven on char when char_valid=0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rec_valid  in  1  record offered
- rec_ready  out  1  high only in IDLE
- rec_time  in  14  decimal time value; clamped to 9999
- rec_pc  in  32  PC, printed as hex
- rec_is_mem  in  1  1 = "*ADDR" form, 0 = "$REG" form
- rec_reg  in  14  register number, printed as decimal; clamped to 9999
- rec_addr  in  32  memory address, printed as hex
- rec_data  in  32  write data, printed as hex
- char  out  8  ASCII output
- char_valid  out  1  char carries a line character
- line_done  out  1  one-cycle pulse, coincident with "#"
- ovf  out  1  sticky; set on any clamp; cleared only by reset

Behaviour:
- Reset values: rec_ready=1, char=IDLE_CHAR, char_valid=0, line_done=0, ovf=0, state=IDLE.
- Handshake and latching:
  - Accept occurs on edge E0 where rec_valid & rec_ready.
  - All fields are latched at E0; upstream inputs may change afterwards.
  - Clamping is applied at latch time: time>9999 becomes 9999, and reg>9999 becomes 9999. Either clamp sets ovf.
- States, in order: IDLE, CONV, CARET, TIME, AT, PC, COLON, SP1, MARK, OPND, SP2, LT, EQ, SP3, DATA, HASH, then back to IDLE.
- CONV:
  - Both BCD converters start at E0 and shift on E1..E14. They run in parallel; the reg converter result is ignored when rec_is_mem=1.
  - During CONV: char_valid=0 and char=IDLE_CHAR.
- Emission timing:
  - "^" is registered at E15.
  - Line length is L = 23 + d_t + opnd + SP_COLON + SP_LT + SP_EQ, where:
    - d_t = decimal digits of time (1..4).
    - opnd = 8 for a memory record, or d_r = decimal digits of reg (1..4) for a register record.
  - Characters are emitted on L consecutive cycles with no gaps and no downstream backpressure.
  - line_done=1 only in the "#" cycle.
  - The state is IDLE (rec_ready=1) from edge E15+L onward. Minimum record period is L+15 cycles.
- Decimal fields:
  - Leading zeros are suppressed. Value 0 prints as "0"; internal zeros are kept (1000 prints as "1000").
  - The digit count is computed from the BCD result, not the binary value.
- Hex fields:
  - Always exactly 8 digits, MSB nibble first.
  - Lowercase a-f; nibble >9 maps to "a"+n-10.
- Mark character is "$" for rec_is_mem=0 and "*" for rec_is_mem=1. "<=" is emitted as two cycles, "<" then "=".
- Zero-space parameters: SP states with count 0 are skipped entirely, with no idle cycle.
- Reset mid-line: on the next edge the block is in IDLE with reset values, and the partial line is dropped. Downstream must be reset together with this block.
- rec_valid in non-IDLE states is ignored; no record is lost as long as upstream holds it until ready.

Decomposition:
- trace_fmt_pkg holds:
  - the state enum;
  - ASCII constants "^", "@", ":", " ", "$", "*", "<", "=", "#";
  - format codes FMT_REG=2'b01, FMT_STO=2'b10, matching the checker;
  - the 9999 clamp limit.
- Sub-module trace_bcd_conv:
  - Iterative double-dabble, 14-bit input to 4 BCD digits.
  - Interface: start, done, digits[15:0].
  - Fixed 14-cycle latency.
  - Instantiated twice, for time and reg.

Test Plan:
- Register line: time=25, pc=0x00003000, reg=3, data=0x0000abcd, default spacing.
  - Emits "^25@00003000: $3 <= 0000abcd#": 29 chars, first char at E15.
  - Checker reports format_type=2'b01 in the cycle after "#".
- Memory line: SP_*=0, time=0, pc=0xdeadbeef, addr=0x00000010, data=0xffffffff.
  - Emits "^0@deadbeef:*00000010<=ffffffff#": 32 chars.
  - Checker reports format_type=2'b10.
- Clamp: time=12345, reg=31.
  - TIME field is "9999"; ovf=1 and stays 1 over the next record.
  - time=1000 prints "1000".
- Back-to-back: rec_valid held high with two records.
  - Second accept occurs exactly at E15+L.
  - Exactly 15 IDLE_CHAR cycles (char_valid=0) between the "#" of line 1 and the "^" of line 2.
  - line_done pulses twice.
- Reset asserted during the PC field.
  - Next cycle: char_valid=0, char=8'h00, rec_ready=1.
  - The following record is emitted complete and correct.
